// File: rtl/prism_comm_fifo_if.sv
// CPU-side register bus bundle for the PRISM comm FIFO pair.
// The master drives address and strobes; the slave returns read data.
interface prism_comm_fifo_if;
  logic        addr;
  logic        wr;
  logic        rd;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output addr,
    output wr,
    output rd,
    output wdata,
    input  rdata
  );

  modport slave (
    input  addr,
    input  wr,
    input  rd,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/prism_comm_fifo.sv
// TX/RX byte FIFO pair between the TinyQV bus and the PRISM shift engine.
// Optional level interrupt is built when PRISM_FIFO_IRQ_EN is defined.
module prism_comm_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  prism_comm_fifo_if.slave bus,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_pop,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             rx_push,
  output logic             irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic data_wr;
  logic data_rd;
  logic ctrl_wr;
  logic tx_flush;
  logic rx_flush;

  assign data_wr  = bus.wr & ~bus.addr;
  assign data_rd  = bus.rd & ~bus.addr;
  assign ctrl_wr  = bus.wr & bus.addr;
  assign tx_flush = ctrl_wr & bus.wdata[0];
  assign rx_flush = ctrl_wr & bus.wdata[1];

  logic [WIDTH-1:0] tx_mem [DEPTH];
  logic [AW-1:0]    tx_wp;
  logic [AW-1:0]    tx_rp;
  logic [CW-1:0]    tx_cnt;
  logic             tx_empty;
  logic             tx_full;
  logic             tx_do_pop;
  logic             tx_do_push;
  logic             tx_ovf_set;

  assign tx_empty   = (tx_cnt == '0);
  assign tx_full    = (tx_cnt == FULL);
  assign tx_do_pop  = tx_pop & ~tx_empty;
  // A push into a full FIFO survives only when a pop frees the slot.
  assign tx_do_push = data_wr & (~tx_full | tx_do_pop);
  assign tx_ovf_set = data_wr & tx_full & ~tx_do_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else if (tx_flush) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_do_push)
        tx_wp <= tx_wp + AW'(1);
      if (tx_do_pop)
        tx_rp <= tx_rp + AW'(1);
      tx_cnt <= tx_cnt + CW'(tx_do_push)
                       - CW'(tx_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_do_push & ~tx_flush)
      tx_mem[tx_wp] <= bus.wdata[WIDTH-1:0];
  end

  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_empty ? '0 : tx_mem[tx_rp];

  logic [WIDTH-1:0] rx_mem [DEPTH];
  logic [AW-1:0]    rx_wp;
  logic [AW-1:0]    rx_rp;
  logic [CW-1:0]    rx_cnt;
  logic             rx_empty;
  logic             rx_full;
  logic             rx_do_pop;
  logic             rx_do_push;
  logic             rx_ovf_set;
  logic             rx_unf_set;
  logic [WIDTH-1:0] rx_head;

  assign rx_empty   = (rx_cnt == '0);
  assign rx_full    = (rx_cnt == FULL);
  assign rx_do_pop  = data_rd & ~rx_empty;
  assign rx_do_push = rx_push & (~rx_full | rx_do_pop);
  // A flush discards the incoming byte, so it is not an overflow.
  assign rx_ovf_set = rx_push & rx_full & ~rx_do_pop & ~rx_flush;
  assign rx_unf_set = data_rd & rx_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else if (rx_flush) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_do_push)
        rx_wp <= rx_wp + AW'(1);
      if (rx_do_pop)
        rx_rp <= rx_rp + AW'(1);
      rx_cnt <= rx_cnt + CW'(rx_do_push)
                       - CW'(rx_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rx_do_push & ~rx_flush)
      rx_mem[rx_wp] <= rx_data;
  end

  assign rx_head = rx_empty ? '0 : rx_mem[rx_rp];

  logic tx_ovf;
  logic rx_ovf;
  logic rx_unf;
  logic clr_tx_ovf;
  logic clr_rx_ovf;
  logic clr_rx_unf;

  assign clr_tx_ovf = ctrl_wr & bus.wdata[24];
  assign clr_rx_ovf = ctrl_wr & bus.wdata[25];
  assign clr_rx_unf = ctrl_wr & bus.wdata[26];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_ovf <= 1'b0;
      rx_ovf <= 1'b0;
      rx_unf <= 1'b0;
    end else begin
      tx_ovf <= tx_ovf_set | (tx_ovf & ~clr_tx_ovf);
      rx_ovf <= rx_ovf_set | (rx_ovf & ~clr_rx_ovf);
      rx_unf <= rx_unf_set | (rx_unf & ~clr_rx_unf);
    end
  end

  logic irq_rx_en;
  logic irq_tx_en;

`ifdef PRISM_FIFO_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_rx_en <= 1'b0;
      irq_tx_en <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        irq_rx_en <= bus.wdata[28];
        irq_tx_en <= bus.wdata[29];
      end
      irq_q <= (irq_rx_en & ~rx_empty)
             | (irq_tx_en & tx_empty);
    end
  end

  assign irq = irq_q;
`else
  assign irq_rx_en = 1'b0;
  assign irq_tx_en = 1'b0;
  assign irq       = 1'b0;
`endif

  logic [31:0] status;

  assign status = {
    2'b00,
    irq_tx_en,
    irq_rx_en,
    1'b0,
    rx_unf,
    rx_ovf,
    tx_ovf,
    6'b0,
    rx_empty,
    tx_full,
    8'(rx_cnt),
    8'(tx_cnt)
  };

  assign bus.rdata = bus.addr ? status
                              : 32'(rx_head);

  logic unused;
  assign unused = ^bus.wdata;

endmodule
